// File: rtl/decode_stage_hz.sv
// ---------------------------------------------------------------------------
// decode_stage_hz
//
// Purpose:
//   ID stage of the 5-stage RV32 pipeline. Decodes InsD, reads the register
//   file (with a same-cycle bypass from WB), builds the sign-extended
//   immediate and ALU control, and registers everything into the ID/EX
//   pipeline register. It also detects load-use hazards and inserts bubbles.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   When defined, an unknown opcode, or a register index >= NREGS in any
//   field the instruction actually uses, is captured as a trap entry:
//   controls are zero, but valid_E=1, illegal_E=1 and PC_E is kept.
//   When undefined, unknown opcodes simply decode to all-zero controls and
//   illegal_E is constant 0.
//
// Parameters:
//   XLEN   datapath width (PC, register data, immediates)
//   NREGS  architectural register count, 32 (RV32I) or 16 (RV32E)
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   stall_i            downstream hold, ID/EX keeps its contents
//   flush_i            redirect, ID/EX takes a bubble
//   valid_D, InsD      instruction in ID and its valid bit
//   PC_D, PC_4D        PC and PC+4 of InsD
//   RegWriteW, RD_W,
//   Result_W           write-back port into the register file
//   hazard_stall_o     combinational load-use stall request to IF/ID and PC
//   *_E                registered ID/EX contents (controls, operands,
//                      immediate, register indices, PCs, illegal flag)
// ---------------------------------------------------------------------------
module decode_stage_hz #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            valid_D,
    input  logic [31:0]     InsD,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] PC_4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RD_W,
    input  logic [XLEN-1:0] Result_W,
    output logic            hazard_stall_o,
    output logic            valid_E,
    output logic            RegWrite_E,
    output logic            ALUSrc_E,
    output logic            MemWrite_E,
    output logic            MemRead_E,
    output logic            Branch_E,
    output logic            Jump_E,
    output logic            MemtoReg_E,
    output logic [3:0]      control_o_E,
    output logic [XLEN-1:0] ImmExt_E,
    output logic [XLEN-1:0] rdata1_E,
    output logic [XLEN-1:0] rdata2_E,
    output logic [4:0]      rs1_E,
    output logic [4:0]      rs2_E,
    output logic [4:0]      rd_E,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] PC_4E,
    output logic            illegal_E
);

    localparam int         IDXW    = $clog2(NREGS);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_kind_e;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            alusrc;
        logic            memwrite;
        logic            memread;
        logic            branch;
        logic            jump;
        logic            memtoreg;
        logic            illegal;
        logic [3:0]      alu_ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } idex_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    logic       dec_regwrite;
    logic       dec_alusrc;
    logic       dec_memwrite;
    logic       dec_memread;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_memtoreg;
    logic [3:0] dec_alu;
    imm_kind_e  imm_kind;
    logic       use_rs1;
    logic       use_rs2;
    logic       illegal;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    logic [XLEN-1:0] regs [NREGS];
    logic            rs1_ok;
    logic            rs2_ok;
    logic            wb_write;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    idex_t cap;
    idex_t ex;

    assign opcode    = InsD[6:0];
    assign funct3    = InsD[14:12];
    assign funct7_b5 = InsD[30];
    assign rs1       = InsD[19:15];
    assign rs2       = InsD[24:20];
    assign rd        = InsD[11:7];

    // funct3 → ALU operation for R-type and I-type ALU instructions.
    // funct7[5] picks SUB only on R-type (on I-type that bit belongs to the
    // immediate), but picks SRA on both R-type and I-type shifts.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                  input logic       alt,
                                                  input logic       is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Main opcode decoder: control bits, ALU op, immediate format, and
    // which source registers the instruction really reads (for hazards
    // and for index checking).
    always_comb begin
        dec_regwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_memtoreg = 1'b0;
        dec_alu      = ALU_AND;
        imm_kind     = IMM_NONE;
        use_rs1      = 1'b1;
        use_rs2      = 1'b0;
        case (opcode)
            OP_R: begin
                dec_regwrite = 1'b1;
                dec_alu      = alu_from_funct(funct3, funct7_b5, 1'b1);
                use_rs2      = 1'b1;
            end
            OP_IMM: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = alu_from_funct(funct3, funct7_b5, 1'b0);
                imm_kind     = IMM_I;
            end
            OP_LOAD: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_alu      = ALU_ADD;
                imm_kind     = IMM_I;
            end
            OP_STORE: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
                dec_alu      = ALU_ADD;
                imm_kind     = IMM_S;
                use_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec_branch   = 1'b1;
                dec_alu      = ALU_SUB;
                imm_kind     = IMM_B;
                use_rs2      = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = ALU_ADD;
                imm_kind     = IMM_U;
                use_rs1      = 1'b0;
            end
            OP_JAL: begin
                dec_regwrite = 1'b1;
                dec_jump     = 1'b1;
                imm_kind     = IMM_J;
                use_rs1      = 1'b0;
            end
            OP_JALR: begin
                dec_regwrite = 1'b1;
                dec_jump     = 1'b1;
                dec_alusrc   = 1'b1;
                dec_alu      = ALU_ADD;
                imm_kind     = IMM_I;
            end
            default: begin
            end
        endcase
    end

    // Immediate assembly. Everything is built as a 32-bit value first and
    // then sign-extended to XLEN, so B and J keep bit 0 at zero.
    always_comb begin
        imm32 = 32'd0;
        case (imm_kind)
            IMM_I: imm32 = {{20{InsD[31]}}, InsD[31:20]};
            IMM_S: imm32 = {{20{InsD[31]}}, InsD[31:25], InsD[11:7]};
            IMM_B: imm32 = {{19{InsD[31]}}, InsD[31], InsD[7], InsD[30:25],
                            InsD[11:8], 1'b0};
            IMM_U: imm32 = {InsD[31:12], 12'd0};
            IMM_J: imm32 = {{11{InsD[31]}}, InsD[31], InsD[19:12], InsD[20],
                            InsD[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // Index range checks. With NREGS=16 the upper half of the index space
    // does not exist: it reads as zero and cannot be written. The write
    // enable folds in the same check so the bypass never forwards a value
    // the file would have dropped.
    always_comb begin
        rs1_ok   = ({1'b0, rs1} < NREGS_W);
        rs2_ok   = ({1'b0, rs2} < NREGS_W);
        wb_write = RegWriteW && (RD_W != 5'd0) && ({1'b0, RD_W} < NREGS_W);
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Trap detection: an opcode outside the supported set, or an
    // out-of-range index in a field this instruction actually uses.
    logic unknown_op;
    logic rd_ok;
    always_comb begin
        unknown_op = !(opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
        rd_ok      = ({1'b0, rd} < NREGS_W);
        illegal    = unknown_op
                   || (use_rs1 && !rs1_ok)
                   || (use_rs2 && !rs2_ok)
                   || (dec_regwrite && !rd_ok);
    end
`else
    assign illegal = 1'b0;
`endif

    // Register file storage. Reset clears every entry. Write-back is
    // independent of the ID/EX register, so it keeps going through stalls,
    // flushes and hazard bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[RD_W[IDXW-1:0]] <= Result_W;
        end
    end

    // Read port 1 with WB bypass; x0 and out-of-range indices read zero.
    always_comb begin
        rdata1 = '0;
        if (rs1 != 5'd0 && rs1_ok) begin
            if (wb_write && RD_W == rs1) begin
                rdata1 = Result_W;
            end else begin
                rdata1 = regs[rs1[IDXW-1:0]];
            end
        end
    end

    // Read port 2, same rules as port 1.
    always_comb begin
        rdata2 = '0;
        if (rs2 != 5'd0 && rs2_ok) begin
            if (wb_write && RD_W == rs2) begin
                rdata2 = Result_W;
            end else begin
                rdata2 = regs[rs2[IDXW-1:0]];
            end
        end
    end

    // Load-use detection against the instruction currently in EX. The
    // request is dropped while stall_i or flush_i is high, because those
    // already decide what ID/EX does this cycle.
    always_comb begin
        hazard_stall_o = valid_D && ex.valid && ex.memread && (ex.rd != 5'd0)
                      && ((use_rs1 && ex.rd == rs1) || (use_rs2 && ex.rd == rs2))
                      && !stall_i && !flush_i;
    end

    // Entry that ID/EX takes on a normal capture. Controls are gated by
    // valid_D so an invalid slot can never write state downstream, and by
    // the illegal flag so a trapping instruction has no side effects while
    // its PC and operands still travel along for the trap handler.
    always_comb begin
        logic ctrl_ok;
        ctrl_ok      = valid_D && !illegal;
        cap          = '0;
        cap.valid    = valid_D;
        cap.regwrite = dec_regwrite && ctrl_ok;
        cap.alusrc   = dec_alusrc && ctrl_ok;
        cap.memwrite = dec_memwrite && ctrl_ok;
        cap.memread  = dec_memread && ctrl_ok;
        cap.branch   = dec_branch && ctrl_ok;
        cap.jump     = dec_jump && ctrl_ok;
        cap.memtoreg = dec_memtoreg && ctrl_ok;
        cap.illegal  = valid_D && illegal;
        cap.alu_ctrl = ctrl_ok ? dec_alu : ALU_AND;
        cap.imm      = imm_ext;
        cap.rdata1   = rdata1;
        cap.rdata2   = rdata2;
        cap.rs1      = rs1;
        cap.rs2      = rs2;
        cap.rd       = rd;
        cap.pc       = PC_D;
        cap.pc4      = PC_4D;
    end

    // ID/EX pipeline register. Priority: reset, flush bubble, external
    // hold, load-use bubble, then normal capture. Bubbles clear the data
    // fields too.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex <= '0;
        end else if (flush_i) begin
            ex <= '0;
        end else if (stall_i) begin
            ex <= ex;
        end else if (hazard_stall_o) begin
            ex <= '0;
        end else begin
            ex <= cap;
        end
    end

    assign valid_E     = ex.valid;
    assign RegWrite_E  = ex.regwrite;
    assign ALUSrc_E    = ex.alusrc;
    assign MemWrite_E  = ex.memwrite;
    assign MemRead_E   = ex.memread;
    assign Branch_E    = ex.branch;
    assign Jump_E      = ex.jump;
    assign MemtoReg_E  = ex.memtoreg;
    assign illegal_E   = ex.illegal;
    assign control_o_E = ex.alu_ctrl;
    assign ImmExt_E    = ex.imm;
    assign rdata1_E    = ex.rdata1;
    assign rdata2_E    = ex.rdata2;
    assign rs1_E       = ex.rs1;
    assign rs2_E       = ex.rs2;
    assign rd_E        = ex.rd;
    assign PC_E        = ex.pc;
    assign PC_4E       = ex.pc4;

endmodule

// File: tb/tb_decode_stage_hz.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_hz
//
// Self-checking bench for decode_stage_hz. A behavioural model of the ID/EX
// contents and of the register file (RV32I instance) is advanced once per
// clock from the instruction-set rules; directed scenarios and a random
// run compare the DUT against it. A second instance with NREGS=16 covers
// the RV32E register limits.
// ---------------------------------------------------------------------------
module tb_decode_stage_hz;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        valid_D;
    logic [31:0] InsD;
    logic [31:0] PC_D;
    logic [31:0] PC_4D;
    logic        RegWriteW;
    logic [4:0]  RD_W;
    logic [31:0] Result_W;

    logic        hazard_stall_o, valid_E, RegWrite_E, ALUSrc_E, MemWrite_E;
    logic        MemRead_E, Branch_E, Jump_E, MemtoReg_E, illegal_E;
    logic [3:0]  control_o_E;
    logic [31:0] ImmExt_E, rdata1_E, rdata2_E, PC_E, PC_4E;
    logic [4:0]  rs1_E, rs2_E, rd_E;

    logic        e_hazard, e_valid, e_regwrite, e_alusrc, e_memwrite;
    logic        e_memread, e_branch, e_jump, e_memtoreg, e_illegal;
    logic [3:0]  e_ctrl;
    logic [31:0] e_imm, e_rd1, e_rd2, e_pc, e_pc4;
    logic [4:0]  e_rs1, e_rs2, e_rd;

    int total = 0;
    int bad   = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    decode_stage_hz #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .valid_D(valid_D), .InsD(InsD), .PC_D(PC_D), .PC_4D(PC_4D),
        .RegWriteW(RegWriteW), .RD_W(RD_W), .Result_W(Result_W),
        .hazard_stall_o(hazard_stall_o), .valid_E(valid_E),
        .RegWrite_E(RegWrite_E), .ALUSrc_E(ALUSrc_E), .MemWrite_E(MemWrite_E),
        .MemRead_E(MemRead_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
        .MemtoReg_E(MemtoReg_E), .control_o_E(control_o_E),
        .ImmExt_E(ImmExt_E), .rdata1_E(rdata1_E), .rdata2_E(rdata2_E),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .PC_E(PC_E),
        .PC_4E(PC_4E), .illegal_E(illegal_E)
    );

    decode_stage_hz #(.XLEN(32), .NREGS(16)) dut16 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .valid_D(valid_D), .InsD(InsD), .PC_D(PC_D), .PC_4D(PC_4D),
        .RegWriteW(RegWriteW), .RD_W(RD_W), .Result_W(Result_W),
        .hazard_stall_o(e_hazard), .valid_E(e_valid),
        .RegWrite_E(e_regwrite), .ALUSrc_E(e_alusrc), .MemWrite_E(e_memwrite),
        .MemRead_E(e_memread), .Branch_E(e_branch), .Jump_E(e_jump),
        .MemtoReg_E(e_memtoreg), .control_o_E(e_ctrl),
        .ImmExt_E(e_imm), .rdata1_E(e_rd1), .rdata2_E(e_rd2),
        .rs1_E(e_rs1), .rs2_E(e_rs2), .rd_E(e_rd), .PC_E(e_pc),
        .PC_4E(e_pc4), .illegal_E(e_illegal)
    );

    typedef struct packed {
        logic        valid, regwrite, alusrc, memwrite, memread;
        logic        branch, jump, memtoreg, illegal;
        logic [3:0]  alu;
        logic [31:0] imm, rd1, rd2;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4;
    } exp_t;

    exp_t        m = '0;
    logic [31:0] rf [32];

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] op);
        return {imm, r1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1);
        return {imm[12], imm[10:5], r2, r1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] d);
        return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (RegWriteW && RD_W == idx) return Result_W;
        return rf[idx];
    endfunction

    function automatic logic [3:0] model_alu(input logic [2:0] f3, input logic alt,
                                             input logic is_r);
        logic [3:0] tbl [8];
        tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        if (f3 == 3'd0 && is_r && alt) return 4'b0110;
        if (f3 == 3'd5 && alt) return 4'b0111;
        return tbl[f3];
    endfunction

    function automatic exp_t model_capture();
        exp_t        e;
        int          s;
        logic        known;
        logic        ok;
        logic [6:0]  op;
        e     = '0;
        s     = InsD;
        op    = InsD[6:0];
        known = 1'b1;
        case (op)
            7'b0110011: begin e.regwrite = 1; e.alu = model_alu(InsD[14:12], InsD[30], 1); end
            7'b0010011: begin e.regwrite = 1; e.alusrc = 1; e.imm = s >>> 20;
                              e.alu = model_alu(InsD[14:12], InsD[30], 0); end
            7'b0000011: begin e.regwrite = 1; e.alusrc = 1; e.memread = 1; e.memtoreg = 1;
                              e.alu = 4'b0010; e.imm = s >>> 20; end
            7'b0100011: begin e.alusrc = 1; e.memwrite = 1; e.alu = 4'b0010;
                              e.imm = (s >>> 25) * 32 + int'(InsD[11:7]); end
            7'b1100011: begin e.branch = 1; e.alu = 4'b0110;
                              e.imm = (s >>> 31) * 4096 + int'(InsD[7]) * 2048
                                    + int'(InsD[30:25]) * 32 + int'(InsD[11:8]) * 2; end
            7'b0110111,
            7'b0010111: begin e.regwrite = 1; e.alusrc = 1; e.alu = 4'b0010;
                              e.imm = InsD & 32'hFFFF_F000; end
            7'b1101111: begin e.regwrite = 1; e.jump = 1;
                              e.imm = (s >>> 31) * 1048576 + int'(InsD[19:12]) * 4096
                                    + int'(InsD[20]) * 2048 + int'(InsD[30:21]) * 2; end
            7'b1100111: begin e.regwrite = 1; e.jump = 1; e.alusrc = 1; e.alu = 4'b0010;
                              e.imm = s >>> 20; end
            default:    known = 1'b0;
        endcase
        ok = valid_D && !(TRAP_EN && !known);
        if (!ok) begin
            e.regwrite = 0; e.alusrc = 0; e.memwrite = 0; e.memread = 0;
            e.branch = 0; e.jump = 0; e.memtoreg = 0; e.alu = 4'b0000;
        end
        e.valid   = valid_D;
        e.illegal = valid_D && TRAP_EN && !known;
        e.rs1     = InsD[19:15];
        e.rs2     = InsD[24:20];
        e.rd      = InsD[11:7];
        e.rd1     = model_read(InsD[19:15]);
        e.rd2     = model_read(InsD[24:20]);
        e.pc      = PC_D;
        e.pc4     = PC_4D;
        return e;
    endfunction

    function automatic logic model_hz();
        logic [6:0] op;
        logic       u1, u2;
        op = InsD[6:0];
        u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return !stall_i && !flush_i && valid_D && m.valid && m.memread && m.rd != 5'd0
            && ((u1 && m.rd == InsD[19:15]) || (u2 && m.rd == InsD[24:20]));
    endfunction

    function automatic exp_t dut_view();
        return {valid_E, RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, Jump_E,
                MemtoReg_E, illegal_E, control_o_E, ImmExt_E, rdata1_E, rdata2_E,
                rs1_E, rs2_E, rd_E, PC_E, PC_4E};
    endfunction

    // Advance one clock: predict the next ID/EX contents and register file
    // from the inputs currently applied, then sample 1 ns after the edge.
    task automatic tick();
        exp_t nxt;
        if (rst)              nxt = '0;
        else if (flush_i)     nxt = '0;
        else if (stall_i)     nxt = m;
        else if (model_hz())  nxt = '0;
        else                  nxt = model_capture();
        @(posedge clk);
        #1;
        m = nxt;
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        end else if (RegWriteW && RD_W != 5'd0) begin
            rf[RD_W] = Result_W;
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic vd,
                         input logic [31:0] ins, input logic rw,
                         input logic [4:0] rdw, input logic [31:0] res);
        rst       = 1'b0;
        stall_i   = st;
        flush_i   = fl;
        valid_D   = vd;
        InsD      = ins;
        PC_D      = $urandom & 32'hFFFF_FFFC;
        PC_4D     = PC_D + 32'd4;
        RegWriteW = rw;
        RD_W      = rdw;
        Result_W  = res;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(0, 0, 1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7), 1, 5'd5, 32'h1111_2222);
        rst = 1'b1;
        tick();
        drive(0, 0, 1, enc_i(12'd0, 5'd2, 3'b010, 5'd4, 7'b0000011), 1, 5'd5, 32'h0000_1234);
        tick();
        drive(1, 0, 1, enc_r(7'h00, 5'd4, 5'd4, 3'd0, 5'd9), 1, 5'd6, 32'h5555_AAAA);
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (dut_view() !== exp_t'(0)) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 0", dut_view());
        end
        total++;
        if (hazard_stall_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_hazard: got %b want 0", hazard_stall_o);
        end
        drive(0, 0, 1, enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd1), 0, 5'd0, 32'd0);
        tick();
        total++;
        if (rdata1_E !== 32'd0 || rdata1_E !== m.rd1) begin
            bad++;
            $display("[TB] FAIL reset_x5: got %h want 0", rdata1_E);
        end
    endtask

    task automatic test_bypass();
        drive(0, 0, 1, enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd1), 1, 5'd3, 32'hDEAD_BEEF);
        tick();
        total++;
        if (rdata1_E !== 32'hDEAD_BEEF || rd_E !== 5'd1 || control_o_E !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL bypass: got rd1=%h rd=%0d alu=%b want deadbeef 1 0010",
                     rdata1_E, rd_E, control_o_E);
        end
        total++;
        if (dut_view() !== m) begin
            bad++;
            $display("[TB] FAIL bypass_model: got %h want %h", dut_view(), m);
        end
        drive(0, 0, 1, enc_r(7'h00, 5'd3, 5'd0, 3'd0, 5'd2), 0, 5'd0, 32'd0);
        tick();
        total++;
        if (rdata2_E !== 32'hDEAD_BEEF || rdata1_E !== 32'd0) begin
            bad++;
            $display("[TB] FAIL regfile_read: got rd1=%h rd2=%h want 0 deadbeef",
                     rdata1_E, rdata2_E);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] lw_x4;
        lw_x4 = enc_i(12'd0, 5'd2, 3'b010, 5'd4, 7'b0000011);
        drive(0, 0, 1, lw_x4, 0, 5'd0, 32'd0);
        tick();
        total++;
        if (MemRead_E !== 1'b1 || rd_E !== 5'd4) begin
            bad++;
            $display("[TB] FAIL load_capture: got mr=%b rd=%0d want 1 4", MemRead_E, rd_E);
        end
        drive(0, 0, 1, enc_r(7'h00, 5'd6, 5'd4, 3'd0, 5'd5), 0, 5'd0, 32'd0);
        #1;
        total++;
        if (hazard_stall_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL load_use_hazard: got %b want 1", hazard_stall_o);
        end
        tick();
        total++;
        if (valid_E !== 1'b0 || RegWrite_E !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_use_bubble: got v=%b rw=%b want 0 0", valid_E, RegWrite_E);
        end
        drive(0, 0, 1, lw_x4, 0, 5'd0, 32'd0);
        tick();
        drive(0, 0, 1, {20'd1, 5'd5, 7'b0110111}, 0, 5'd0, 32'd0);
        #1;
        total++;
        if (hazard_stall_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lui_no_hazard: got %b want 0", hazard_stall_o);
        end
        tick();
        total++;
        if (valid_E !== 1'b1 || RegWrite_E !== 1'b1 || ImmExt_E !== 32'h0000_1000) begin
            bad++;
            $display("[TB] FAIL lui_capture: got v=%b rw=%b imm=%h want 1 1 00001000",
                     valid_E, RegWrite_E, ImmExt_E);
        end
        drive(0, 0, 1, lw_x4, 0, 5'd0, 32'd0);
        tick();
        drive(1, 0, 1, enc_r(7'h00, 5'd4, 5'd1, 3'd0, 5'd5), 0, 5'd0, 32'd0);
        #1;
        total++;
        if (hazard_stall_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hazard_masked_by_stall: got %b want 0", hazard_stall_o);
        end
        drive(0, 0, 1, enc_r(7'h00, 5'd4, 5'd1, 3'd0, 5'd5), 0, 5'd0, 32'd0);
        rst = 1'b1;
        tick();
        total++;
        if (dut_view() !== exp_t'(0)) begin
            bad++;
            $display("[TB] FAIL reset_mid_hazard: got %h want 0", dut_view());
        end
    endtask

    task automatic test_flush_stall();
        exp_t        hold;
        logic [31:0] sub_ins;
        sub_ins = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7);
        drive(1, 1, 1, sub_ins, 0, 5'd0, 32'd0);
        tick();
        total++;
        if (valid_E !== 1'b0 || dut_view() !== exp_t'(0)) begin
            bad++;
            $display("[TB] FAIL flush_over_stall: got %h want 0", dut_view());
        end
        drive(0, 0, 1, sub_ins, 0, 5'd0, 32'd0);
        tick();
        hold = m;
        total++;
        if (valid_E !== 1'b1 || control_o_E !== 4'b0110 || rd_E !== 5'd7) begin
            bad++;
            $display("[TB] FAIL sub_capture: got v=%b alu=%b rd=%0d want 1 0110 7",
                     valid_E, control_o_E, rd_E);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, enc_i(12'h7FF, 5'd1, 3'b000, 5'd9, 7'b0010011),
                  1, 5'd1, $urandom);
            tick();
            total++;
            if (dut_view() !== hold) begin
                bad++;
                $display("[TB] FAIL stall_hold_%0d: got %h want %h", k, dut_view(), hold);
            end
        end
    endtask

    task automatic test_immediates();
        drive(0, 0, 1, enc_b(13'h1FF8, 5'd2, 5'd1), 0, 5'd0, 32'd0);
        tick();
        total++;
        if (ImmExt_E !== 32'hFFFF_FFF8 || Branch_E !== 1'b1 || control_o_E !== 4'b0110) begin
            bad++;
            $display("[TB] FAIL beq_imm: got imm=%h br=%b alu=%b want fffffff8 1 0110",
                     ImmExt_E, Branch_E, control_o_E);
        end
        drive(0, 0, 1, enc_j(21'd2048, 5'd1), 0, 5'd0, 32'd0);
        tick();
        total++;
        if (ImmExt_E !== 32'h0000_0800 || Jump_E !== 1'b1 || RegWrite_E !== 1'b1) begin
            bad++;
            $display("[TB] FAIL jal_imm: got imm=%h j=%b rw=%b want 00000800 1 1",
                     ImmExt_E, Jump_E, RegWrite_E);
        end
    endtask

    task automatic test_rv32e();
        drive(0, 0, 1, enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'b0010011), 1, 5'd20, 32'hCAFE_F00D);
        tick();
        drive(0, 0, 1, enc_r(7'h00, 5'd0, 5'd20, 3'd0, 5'd1), 0, 5'd0, 32'd0);
        tick();
        total++;
        if (e_rd1 !== 32'd0 || rdata1_E !== 32'hCAFE_F00D) begin
            bad++;
            $display("[TB] FAIL rv32e_x20: got e16=%h e32=%h want 0 cafef00d", e_rd1, rdata1_E);
        end
        drive(0, 0, 1, enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd20), 0, 5'd0, 32'd0);
        tick();
        total++;
        if (e_illegal !== TRAP_EN || e_regwrite !== !TRAP_EN || e_valid !== 1'b1
            || e_pc !== PC_D) begin
            bad++;
            $display("[TB] FAIL rv32e_rd20: got ill=%b rw=%b v=%b pc=%h want %b %b 1 %h",
                     e_illegal, e_regwrite, e_valid, e_pc, TRAP_EN, !TRAP_EN, PC_D);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [11];
        logic [31:0] ins;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};
        for (int n = 0; n < 400; n++) begin
            ins        = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 7) != 0, ins, 1'($urandom),
                  5'($urandom_range(0, 7)), $urandom);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            total++;
            if (hazard_stall_o !== model_hz()) begin
                bad++;
                $display("[TB] FAIL rand_hazard_%0d: got %b want %b", n, hazard_stall_o,
                         model_hz());
            end
            tick();
            total++;
            if (dut_view() !== m) begin
                bad++;
                $display("[TB] FAIL rand_idex_%0d: got %h want %h", n, dut_view(), m);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        drive(0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
        test_reset();
        test_bypass();
        test_load_use();
        test_flush_stall();
        test_immediates();
        test_rv32e();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised successor to the ID stage of the 5-stage RV32 pipeline: decodes InsD, reads the register file with WB bypass, generates immediates and ALU control, and registers everything into the ID/EX pipeline register.
- Adds what the previous stage lacks: valid bit, external stall and flush, load-use hazard detection with bubble insertion, jump decode, a configurable register count (RV32I/RV32E), and a correct rd_E.

Parameters:
- XLEN, 32, datapath width for PC, register data and immediates.
- NREGS, 32, architectural register count; legal values are 32 (RV32I) or 16 (RV32E).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  downstream hold; ID/EX keeps its contents.
- flush_i  in  1  branch/jump redirect; inserts a bubble into ID/EX.
- valid_D  in  1  InsD holds a real instruction.
- InsD  in  32  instruction in ID.
- PC_D, PC_4D  in  XLEN  PC and PC+4 of InsD.
- RegWriteW  in  1  WB write enable.
- RD_W  in  5  WB destination register.
- Result_W  in  XLEN  WB data.
- hazard_stall_o  out  1  combinational load-use stall request to IF/ID and PC.
- valid_E  out  1  ID/EX holds a real instruction.
- RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E, Branch_E, Jump_E, MemtoReg_E  out  1 each  registered controls.
- control_o_E  out  4  ALU operation.
- ImmExt_E, rdata1_E, rdata2_E  out  XLEN  immediate and operands.
- rs1_E, rs2_E, rd_E  out  5  register indices (InsD[19:15], [24:20], [11:7]).
- PC_E, PC_4E  out  XLEN  pipelined PCs.
- illegal_E  out  1  illegal instruction flag (see Optional Feature).

Behaviour:
- All outputs are registered, except hazard_stall_o. Latency is 1 cycle from ID to EX.
- Reset (rst=1 at a clock edge): every output register and every register-file entry is 0. This also holds when reset arrives mid-stall or mid-hazard.
- ID/EX update priority per edge: rst > flush_i (bubble) > stall_i (hold all) > hazard_stall_o (bubble) > capture.
- Capture condition: the captured valid_E equals valid_D.
- Bubble: valid_E and all control bits (RegWrite, MemWrite, MemRead, Branch, Jump, MemtoReg, ALUSrc, illegal) are 0. Data fields are don't-care but are driven to 0.
- Hazard:
  - hazard_stall_o = valid_D & valid_E & MemRead_E & (rd_E!=0) & ((use_rs1 & rd_E==rs1) | (use_rs2 & rd_E==rs2)).
  - use_rs1 is 0 for LUI, AUIPC and JAL.
  - use_rs2 is 1 only for R-type, STORE and BRANCH.
  - hazard_stall_o is forced to 0 while stall_i or flush_i is high.
- Decode by opcode:
  - R 0110011: RegWrite, ALUOp=R.
  - I-ALU 0010011: RegWrite, ALUSrc.
  - LOAD 0000011: RegWrite, ALUSrc, MemRead, MemtoReg, ADD.
  - STORE 0100011: ALUSrc, MemWrite, ADD.
  - BRANCH 1100011: Branch, SUB.
  - LUI 0110111: RegWrite, ALUSrc, ADD.
  - AUIPC 0010111: RegWrite, ALUSrc, ADD.
  - JAL 1101111: RegWrite, Jump.
  - JALR 1100111: RegWrite, Jump, ALUSrc, ADD.
  - Any other opcode: all controls 0.
- ALU encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
  - funct7[5] selects SUB for R-type only, and SRA for R-type and I-type shifts.
- Immediates are I/S/B/U/J per ISA, sign-extended to XLEN. B and J immediates have bit0=0.
- Register file:
  - NREGS entries; x0 reads as 0.
  - Write at the edge when RegWriteW & RD_W!=0 & RD_W<NREGS.
  - Indices >= NREGS read 0 and writes to them are ignored.
  - Read bypass: if RegWriteW & RD_W==rs & rs!=0, the read returns Result_W in the same cycle.
  - Register-file writes proceed during stall_i, flush_i and hazard cycles.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - An unknown opcode, or an RV32E index >= NREGS in any used field, makes a bubble-like entry: controls 0, but valid_E and illegal_E are captured as 1, with PC_E preserved for trap handling.
- When undefined:
  - Unknown opcodes decode to all-zero controls with valid_E=valid_D.
  - illegal_E is constant 0 and no index checking is performed.

Test Plan:
- Reset: after rst=1 for 2 cycles, all outputs are 0 and reading x5 returns 0.
- WB bypass: RegWriteW=1, RD_W=3, Result_W=0xDEADBEEF, InsD=add x1,x3,x0 in the same cycle -> next cycle rdata1_E=0xDEADBEEF, rd_E=1, control_o_E=0010.
- Load-use: lw x4,0(x2) captured into EX, then InsD=add x5,x4,x6 -> hazard_stall_o=1 and next cycle valid_E=0, RegWrite_E=0. With InsD=lui x5,1 instead -> no stall.
- Flush priority: flush_i=1 and stall_i=1 with a valid sub -> next cycle valid_E=0; with stall_i=1 alone, the ID/EX contents are unchanged over 3 cycles.
- Immediates: beq with imm -8 -> ImmExt_E=0xFFFFFFF8, Branch_E=1, control_o_E=0110; jal with imm +2048 -> ImmExt_E=0x00000800, Jump_E=1.
- NREGS=16: write to x20 is ignored and a read of x20 returns 0. With DECODE_ILLEGAL_TRAP_EN, add x20,x1,x1 -> illegal_E=1, RegWrite_E=0, valid_E=1.
